// File: rtl/prio_arb_8_if.sv
// Request/grant bundle between the requester agents and the 8-way arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants.
interface prio_arb_8_if;
    logic [7:0] req;
    logic       done;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output req, done, mode,
        input  gnt, gnt_id, gnt_vld, timeout
    );

    modport slave (
        input  req, done, mode,
        output gnt, gnt_id, gnt_vld, timeout
    );
endinterface

// File: rtl/prio_arb_8.sv
// Eight-way arbiter for a shared datapath: fixed-priority or round-robin choice,
// grant held until done, owner request drop, or the hold limit expires.
module prio_arb_8 #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    prio_arb_8_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? {CNT_W{1'b0}} : CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       last_id;
    logic [7:0]       gnt_p1;
    logic [2:0]       gnt_id_p1;
    logic             vld_p1;
    logic             timeout_p1;

    logic [2:0]       win;
    logic             user_rel;
    logic             hold_hit;

    // Highest set index wins; a zero vector yields 0 but is never used.
    function automatic logic [2:0] fixed_pick(input logic [7:0] r);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) w = 3'(i);
        end
        return w;
    endfunction

    // Search downward from last-1 with wrap, so the previous winner comes last.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = last;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last - 3'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        win      = bus.mode ? rr_pick(bus.req, last_id) : fixed_pick(bus.req);
        user_rel = bus.done || !bus.req[gnt_id_p1];
        hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_id    <= 3'd0;
            gnt_p1     <= 8'd0;
            gnt_id_p1  <= 3'd0;
            vld_p1     <= 1'b0;
            timeout_p1 <= 1'b0;
        end else begin
            timeout_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_p1    <= 8'(1) << win;
                        gnt_id_p1 <= win;
                        vld_p1    <= 1'b1;
                        hold_cnt  <= '0;
                        last_id   <= win;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (hold_cnt != {CNT_W{1'b1}}) hold_cnt <= hold_cnt + 1'b1;
                    // Timeout is flagged only when the limit alone forced the release.
                    if (user_rel || hold_hit) begin
                        gnt_p1     <= 8'd0;
                        gnt_id_p1  <= 3'd0;
                        vld_p1     <= 1'b0;
                        timeout_p1 <= !user_rel;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_p1;
    assign bus.gnt_id  = gnt_id_p1;
    assign bus.gnt_vld = vld_p1;
    assign bus.timeout = timeout_p1;

endmodule
